// File: rtl/channel_burst_arbiter_if.sv
// Channel handshake bundles: a single d/v/a channel and an M-wide array of them.
// The master side drives data and valid; the slave side returns the ack.
interface channel_if #(parameter int N = 32);
  logic [N-1:0] d;
  logic         v;
  logic         a;

  modport master (output d, output v, input a);
  modport slave  (input d, input v, output a);
endinterface

interface channel_array_if #(parameter int M = 4, parameter int N = 32);
  logic [M-1:0][N-1:0] d;
  logic [M-1:0]        v;
  logic [M-1:0]        a;

  modport master (output d, output v, input a);
  modport slave  (input d, input v, output a);
endinterface

// File: rtl/channel_burst_arbiter.sv
// Round-robin arbiter merging M channels into one registered output channel,
// holding each grant for a burst of up to BurstMax words.
module channel_burst_arbiter #(
  parameter int M        = 4,
  parameter int N        = 32,
  parameter int BurstMax = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  channel_array_if.slave       in,
  channel_if.master            out,
  input  logic [M-1:0]         enable,
  output logic [$clog2(M)-1:0] grant_id,
  output logic                 busy
);

  localparam int IW = $clog2(M);
  localparam int CW = $clog2(BurstMax + 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] count;
  logic          outV;
  logic [N-1:0]  outD;

  logic          accept;
  logic          found;
  logic          transfer;
  logic [IW-1:0] scanSel;
  logic [IW-1:0] sel;
  logic [M-1:0]  cand;

  function automatic logic [IW-1:0] nextIdx(input logic [IW-1:0] i);
    return (i == IW'(M - 1)) ? '0 : i + 1'b1;
  endfunction

  assign cand  = in.v & enable;
  assign busy  = (state == LOCKED);
  assign out.v = outV;
  assign out.d = outD;

  // First enabled, valid requester at or after ptr, wrapping around.
  always_comb begin : scanLogic
    int idx;
    idx     = 0;
    found   = 1'b0;
    scanSel = ptr;
    for (int k = 0; k < M; k++) begin
      idx = (int'(ptr) + k) % M;
      if (!found && cand[IW'(idx)]) begin
        found   = 1'b1;
        scanSel = IW'(idx);
      end
    end
  end

  always_comb begin
    accept   = ~outV | out.a;
    sel      = (state == LOCKED) ? grant_id : scanSel;
    transfer = accept & ((state == LOCKED) ? (in.v[grant_id] & enable[grant_id]) : found);
    in.a     = '0;
    if (transfer) in.a[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      count    <= '0;
      outV     <= 1'b0;
      outD     <= '0;
      grant_id <= '0;
    end else begin
      if (accept) begin
        outV <= transfer;
        if (transfer) outD <= in.d[sel];
      end
      case (state)
        IDLE: begin
          if (transfer) begin
            grant_id <= scanSel;
            count    <= CW'(1);
            if (BurstMax == 1) ptr <= nextIdx(scanSel);
            else               state <= LOCKED;
          end
        end
        LOCKED: begin
          // A stall (accept low) never ends the burst; only disable, a gap or the limit does.
          if (!enable[grant_id]) begin
            state <= IDLE;
            ptr   <= nextIdx(grant_id);
          end else if (accept) begin
            if (in.v[grant_id]) begin
              count <= count + 1'b1;
              if (count + 1'b1 == CW'(BurstMax)) begin
                state <= IDLE;
                ptr   <= nextIdx(grant_id);
              end
            end else begin
              state <= IDLE;
              ptr   <= nextIdx(grant_id);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_burst_arbiter.sv
// Randomized bench for channel_burst_arbiter, checked every cycle against a
// behavioural grant/burst model, plus directed literal checks (BurstMax 8 and 1).
module tb_channel_burst_arbiter;

  localparam int M  = 4;
  localparam int N  = 32;
  localparam int B  = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] en;
  logic [3:0] en1;
  logic [1:0] grantId;
  logic [1:0] grantId1;
  logic       busy;
  logic       busy1;

  int checks   = 0;
  int failures = 0;

  channel_array_if #(.M(M), .N(N)) inBus ();
  channel_if       #(.N(N))        outBus ();
  channel_array_if #(.M(M), .N(N)) inBus1 ();
  channel_if       #(.N(N))        outBus1 ();

  channel_burst_arbiter #(.M(M), .N(N), .BurstMax(B)) dut (
    .clk(clk), .reset(reset), .in(inBus), .out(outBus),
    .enable(en), .grant_id(grantId), .busy(busy)
  );

  channel_burst_arbiter #(.M(M), .N(N), .BurstMax(1)) dut1 (
    .clk(clk), .reset(reset), .in(inBus1), .out(outBus1),
    .enable(en1), .grant_id(grantId1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Model: who owns the channel, how many words moved, where the next scan starts,
  // and what word the output register holds.
  bit          mLocked;
  int          mOwner;
  int          mCnt;
  int          mStart;
  bit          mOutV;
  logic [31:0] mOutD;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [3:0] expAck;
    bit         accept;
    int         ackIdx;
    expAck = '0;
    ackIdx = -1;
    accept = !mOutV || outBus.a;

    checkValue("busy", {31'd0, busy}, {31'd0, mLocked});
    if (mLocked) checkValue("grant_id", {30'd0, grantId}, 32'(mOwner));
    checkValue("out_v", {31'd0, outBus.v}, {31'd0, mOutV});
    if (mOutV) checkValue("out_d", outBus.d, mOutD);

    if (mLocked) begin
      if (!en[2'(mOwner)]) begin
        mLocked = 0;
        mStart  = (mOwner + 1) % M;
      end else if (accept) begin
        if (inBus.v[2'(mOwner)]) begin
          ackIdx = mOwner;
          mCnt++;
          if (mCnt == B) begin
            mLocked = 0;
            mStart  = (mOwner + 1) % M;
          end
        end else begin
          mLocked = 0;
          mStart  = (mOwner + 1) % M;
        end
      end
    end else if (accept) begin
      for (int k = 0; k < M; k++) begin
        int i;
        i = (mStart + k) % M;
        if (ackIdx < 0 && inBus.v[2'(i)] && en[2'(i)]) ackIdx = i;
      end
      if (ackIdx >= 0) begin
        mOwner  = ackIdx;
        mCnt    = 1;
        mLocked = 1;
      end
    end

    if (ackIdx >= 0) expAck[2'(ackIdx)] = 1'b1;
    checkValue("in_a", {28'd0, inBus.a}, {28'd0, expAck});

    if (accept) begin
      mOutV = (ackIdx >= 0);
      if (ackIdx >= 0) mOutD = inBus.d[2'(ackIdx)];
    end

    if (!reset) begin
      mLocked = 0;
      mOwner  = 0;
      mCnt    = 0;
      mStart  = 0;
      mOutV   = 0;
      mOutD   = '0;
    end
  endtask

  // mode 1: random traffic, backpressure, enables and rare resets; mode 2: all valid.
  task automatic applyStimulus(input int mode);
    for (int i = 0; i < M; i++) inBus.d[i] = {8'(i), 24'($urandom)};
    if (mode == 2) begin
      inBus.v  = 4'hF;
      en       = 4'hF;
      outBus.a = 1'b1;
    end else begin
      for (int i = 0; i < M; i++) begin
        inBus.v[i] = ($urandom_range(0, 6) != 0);
        en[i]      = ($urandom_range(0, 15) != 0);
      end
      outBus.a = ($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 199) != 0);
    end
  endtask

  task automatic runCycle();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mLocked = 0; mOwner = 0; mCnt = 0; mStart = 0; mOutV = 0; mOutD = '0;
    reset    = 1'b0;
    inBus.v  = '0;
    inBus.d  = '0;
    en       = 4'hF;
    outBus.a = 1'b1;
    inBus1.v = 4'b1001;
    en1      = 4'hF;
    outBus1.a = 1'b1;
    for (int i = 0; i < M; i++) inBus1.d[i] = {8'(i), 24'h0};

    @(posedge clk);
    #1;
    runCycle();
    runCycle();
    checkValue("reset_out_v", {31'd0, outBus.v}, 32'd0);
    checkValue("reset_busy", {31'd0, busy}, 32'd0);
    checkValue("reset_grant_id", {30'd0, grantId}, 32'd0);

    // Only input 2 valid with A, B, C.
    reset      = 1'b1;
    inBus.v    = 4'b0100;
    inBus.d[2] = 32'hAAAA_0001;
    runCycle();
    checkValue("abc_out_a", outBus.d, 32'hAAAA_0001);
    checkValue("abc_busy", {31'd0, busy}, 32'd1);
    checkValue("abc_grant", {30'd0, grantId}, 32'd2);
    inBus.d[2] = 32'hBBBB_0002;
    runCycle();
    checkValue("abc_out_b", outBus.d, 32'hBBBB_0002);
    inBus.d[2] = 32'hCCCC_0003;
    runCycle();
    checkValue("abc_out_c", outBus.d, 32'hCCCC_0003);
    inBus.v = 4'b0000;
    runCycle();
    checkValue("abc_idle", {31'd0, busy}, 32'd0);
    checkValue("abc_drain", {31'd0, outBus.v}, 32'd0);
    inBus.v = 4'hF;
    for (int i = 0; i < M; i++) inBus.d[i] = {8'(i), 24'h55};
    runCycle();
    checkValue("abc_next_grant", {30'd0, grantId}, 32'd3);
    checkValue("abc_next_data", outBus.d, 32'h0300_0055);

    // Fairness with BurstMax 8 and alternation with BurstMax 1 after a common reset.
    reset = 1'b0;
    applyStimulus(2);
    runCycle();
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(2);
      runCycle();
      checkValue("fair_src", {24'd0, outBus.d[31:24]}, 32'((c / B) % M));
      if (c < 8) begin
        checkValue("b1_v", {31'd0, outBus1.v}, 32'd1);
        checkValue("b1_src", {24'd0, outBus1.d[31:24]}, (c % 2 == 0) ? 32'd0 : 32'd3);
        checkValue("b1_busy", {31'd0, busy1}, 32'd0);
      end
    end

    for (int c = 0; c < 3000; c++) begin
      applyStimulus(1);
      runCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
